// File: rtl/count_event_capture.sv
`default_nettype none
// ============================================================================
// Module      : count_event_capture
// Description : Observes an up/down counter output and records wrap,
//               threshold-entry and load events into a small FIFO with
//               valid/ready drain, sticky overflow and a saturating wrap
//               counter.
// Ports       : clk        - single clock, rising edge
//               rst        - asynchronous reset, active low
//               count_in   - observed counter value
//               mode       - counter direction (1 = up, 0 = down)
//               load       - counter load strobe
//               thresh     - threshold compare value
//               thresh_en  - enables threshold events
//               evt_ready  - consumer ready
//               clr_ovf    - clears the sticky overflow flag
//               evt_valid  - FIFO head holds an event
//               evt_type   - head type: 00 wrap up, 01 wrap down,
//                            10 threshold, 11 load
//               evt_value  - count_in captured with the head event
//               overflow   - sticky, an event was dropped
//               wrap_cnt   - saturating count of detected wraps
// Revision    : 1.0 - initial release
// ============================================================================
module count_event_capture #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] thresh,
    input  logic             thresh_en,
    input  logic             evt_ready,
    input  logic             clr_ovf,
    output logic             evt_valid,
    output logic [1:0]       evt_type,
    output logic [WIDTH-1:0] evt_value,
    output logic             overflow,
    output logic [15:0]      wrap_cnt
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = c_AW + 1;

    localparam logic [c_CW-1:0]  c_FULL      = c_CW'(DEPTH);
    localparam logic [WIDTH-1:0] c_ONES      = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_ZERO      = {WIDTH{1'b0}};
    localparam logic [15:0]      c_WRAP_MAX  = 16'hFFFF;

    localparam logic [1:0] c_EVT_WRAP_UP = 2'b00;
    localparam logic [1:0] c_EVT_WRAP_DN = 2'b01;
    localparam logic [1:0] c_EVT_THRESH  = 2'b10;
    localparam logic [1:0] c_EVT_LOAD    = 2'b11;

    // History of the previous sampled cycle
    logic [WIDTH-1:0] r_prev_q;
    logic             r_load_q;
    logic             r_prev_valid;

    // FIFO state; each entry is {type, value}
    logic [WIDTH+1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    logic             r_overflow;
    logic [15:0]      r_wrap_cnt;

    logic             w_wrap_up;
    logic             w_wrap_dn;
    logic             w_thresh_hit;
    logic             w_evt;
    logic [1:0]       w_evt_type;
    logic             w_full;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_drop;

    // A load in the previous cycle makes the counter jump, so any apparent
    // wrap across that jump is not a real wrap.
    assign w_wrap_up    = r_prev_valid & ~r_load_q & mode
                        & (r_prev_q == c_ONES) & (count_in == c_ZERO);
    assign w_wrap_dn    = r_prev_valid & ~r_load_q & ~mode
                        & (r_prev_q == c_ZERO) & (count_in == c_ONES);
    // Entry edge only: a value held at the threshold fires once.
    assign w_thresh_hit = r_prev_valid & thresh_en
                        & (count_in == thresh) & (r_prev_q != thresh);

    // One event per cycle: load beats wrap beats threshold.
    always_comb begin
        w_evt      = 1'b0;
        w_evt_type = c_EVT_WRAP_UP;
        if (r_load_q) begin
            w_evt      = 1'b1;
            w_evt_type = c_EVT_LOAD;
        end else if (w_wrap_up) begin
            w_evt      = 1'b1;
            w_evt_type = c_EVT_WRAP_UP;
        end else if (w_wrap_dn) begin
            w_evt      = 1'b1;
            w_evt_type = c_EVT_WRAP_DN;
        end else if (w_thresh_hit) begin
            w_evt      = 1'b1;
            w_evt_type = c_EVT_THRESH;
        end
    end

    assign w_full    = (r_count == c_FULL);
    assign w_pop     = (r_count != '0) & evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = w_evt & (~w_full | w_pop);
    assign w_drop    = w_evt & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_q     <= '0;
            r_load_q     <= 1'b0;
            r_prev_valid <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_wrap_cnt   <= '0;
        end else begin
            r_prev_q     <= count_in;
            r_load_q     <= load;
            r_prev_valid <= 1'b1;

            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase

            // Setting wins over a simultaneous clear.
            r_overflow <= w_drop | (r_overflow & ~clr_ovf);

            if ((w_wrap_up | w_wrap_dn) && (r_wrap_cnt != c_WRAP_MAX)) begin
                r_wrap_cnt <= r_wrap_cnt + 16'd1;
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {w_evt_type, count_in};
        end
    end

    assign evt_valid = (r_count != '0);
    assign evt_type  = evt_valid ? r_mem[r_rd_ptr][WIDTH+1:WIDTH] : 2'b00;
    assign evt_value = evt_valid ? r_mem[r_rd_ptr][WIDTH-1:0]     : c_ZERO;
    assign overflow  = r_overflow;
    assign wrap_cnt  = r_wrap_cnt;

endmodule
`default_nettype wire

// File: doc/count_event_capture.md
COUNT_EVENT_CAPTURE -- requirements
Module: count_event_capture

Interface
REQ-001 Parameter DEPTH, default 4, number of event FIFO entries (power of two, 2..16).
REQ-002 Parameter WIDTH, default 32, width of observed count and threshold.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 count_in  input  WIDTH  count value from the upstream 32-bit counter output (data_out).
REQ-006 mode  input  1  counter direction as driven to the counter: 1 = up, 0 = down.
REQ-007 load  input  1  load strobe as driven to the counter.
REQ-008 thresh  input  WIDTH  threshold compare value.
REQ-009 thresh_en  input  1  enables threshold events.
REQ-010 evt_ready  input  1  consumer ready.
REQ-011 clr_ovf  input  1  clears the overflow flag.
REQ-012 evt_valid  output  1  FIFO head holds a valid event.
REQ-013 evt_type  output  2  head event type: 00 WRAP_UP, 01 WRAP_DOWN, 10 THRESH, 11 LOAD.
REQ-014 evt_value  output  WIDTH  count_in captured with the head event.
REQ-015 overflow  output  1  sticky, an event was dropped.
REQ-016 wrap_cnt  output  16  total wrap events detected, saturating.

Function
REQ-017 Block SHALL register prev_q <= count_in, load_q <= load and prev_valid <= 1 every cycle.
REQ-018 WRAP_UP SHALL be detected when prev_valid=1, load_q=0, mode=1, prev_q=all-ones and count_in=0.
REQ-019 WRAP_DOWN SHALL be detected when prev_valid=1, load_q=0, mode=0, prev_q=0 and count_in=all-ones.
REQ-020 THRESH SHALL be detected when prev_valid=1, thresh_en=1, count_in=thresh and prev_q!=thresh (entry edge only, no repeat while held).
REQ-021 LOAD SHALL be detected when load_q=1, capturing count_in (the loaded value).
REQ-022 At most one event SHALL be generated per cycle; priority LOAD > WRAP_UP/WRAP_DOWN > THRESH; lower-priority events that cycle are discarded without setting overflow.
REQ-023 A detected event SHALL be pushed into the FIFO at the same rising edge; evt_valid SHALL be high after that edge if the FIFO was empty (1-cycle latency from sampled inputs).
REQ-024 Pop SHALL occur on a rising edge with evt_valid=1 and evt_ready=1; evt_type/evt_value SHALL be stable while evt_valid=1 and evt_ready=0.
REQ-025 FIFO full with push and pop in the same cycle SHALL accept the push (count unchanged).
REQ-026 FIFO full with push and no pop SHALL drop the new event and set overflow.
REQ-027 overflow SHALL remain set until clr_ovf=1; simultaneous set and clr_ovf SHALL leave overflow set.
REQ-028 FIFO empty with push and evt_ready=1 SHALL not bypass; event appears on outputs after the push edge.
REQ-029 wrap_cnt SHALL increment on every WRAP_UP/WRAP_DOWN detected (including dropped), saturating at 16'hFFFF.
REQ-030 FIFO order SHALL be strictly first-in first-out; pointers wrap modulo DEPTH.

Reset
REQ-031 rst=0 SHALL asynchronously clear prev_q, load_q, prev_valid, FIFO pointers/occupancy, overflow, wrap_cnt; evt_valid=0, evt_type=0, evt_value=0.
REQ-032 First sampled cycle after reset release SHALL generate no WRAP or THRESH event (prev_valid=0).
REQ-033 Reset asserted mid-operation SHALL discard all queued events; no event from pre-reset state SHALL appear after release.

Verification
REQ-034 Up wrap: mode=1, count_in FFFFFFFE, FFFFFFFF, 00000000, evt_ready=1 -> one event type 00, value 0, wrap_cnt=1.
REQ-035 Down wrap: mode=0, count_in 1, 0, FFFFFFFF -> one event type 01, value FFFFFFFF, wrap_cnt=1.
REQ-036 Threshold: thresh=0x10, thresh_en=1, count_in 0x0E..0x12 then held 0x10 for 3 cycles after re-entry -> exactly two type 10 events, value 0x10.
REQ-037 Load priority: load=1 with data 0xFFFFFFFF then count_in 0 with mode=1 next cycle -> single type 11 event, no wrap event, wrap_cnt unchanged.
REQ-038 Backpressure: evt_ready=0, generate 5 events with DEPTH=4 -> 4 queued in order, overflow=1; drain with evt_ready=1 -> 4 events in order, evt_valid=0; clr_ovf pulse -> overflow=0.
REQ-039 Reset mid-stream: 3 queued events, rst=0 for 2 cycles -> evt_valid=0, wrap_cnt=0, overflow=0, no events after release until a new detection.
